// File: rtl/ddr_pmon_lockchk.sv
// ddr_pmon_lockchk
//   Lock-check sequencer that sits downstream of the PMON frequency detector.
//   It pulses the detector's measurement enable, waits for the detector's done
//   flag, and compares each captured PLL-cycle count against a cmp +/- range
//   window. After the required number of consecutive in-window results it
//   declares PLL lock. It also reports lock loss and a done-wait timeout.
//
// Ports
//   i_clk, i_rst_n    controller clock, asynchronous active-low reset
//   i_enable          run lock checking; low aborts to IDLE
//   i_force_lock      force o_lock high, one cycle after assertion
//   i_cmp, i_range    expected count and allowed +/- deviation
//   i_pass_cnt        consecutive passes needed for lock (0 behaves as 1)
//   i_timeout         max cycles to wait for done (0 disables the timeout)
//   i_done            detector done, asynchronous to i_clk
//   i_lockresult      detector count, stable while done is high
//   o_plllock_en      measurement enable to the detector
//   o_busy            sequencer not idle
//   o_lock            lock status
//   o_fail            one-cycle pulse per out-of-window result
//   o_err_timeout     sticky done-wait timeout
//   o_last_result     last captured count
//   o_meas_cnt        completed measurements, saturating

// Two-flop synchronizer with an active-high asynchronous reset.
module ddr_demet_r (
  input  logic clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module ddr_pmon_lockchk #(
  parameter int PASS_W = 4,
  parameter int TMO_W  = 16,
  parameter int GAP    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_force_lock,
  input  logic [23:0]       i_cmp,
  input  logic [9:0]        i_range,
  input  logic [PASS_W-1:0] i_pass_cnt,
  input  logic [TMO_W-1:0]  i_timeout,
  input  logic              i_done,
  input  logic [23:0]       i_lockresult,
  output logic              o_plllock_en,
  output logic              o_busy,
  output logic              o_lock,
  output logic              o_fail,
  output logic              o_err_timeout,
  output logic [23:0]       o_last_result,
  output logic [7:0]        o_meas_cnt
);

  localparam int GAP_W = $clog2(GAP + 1);
  // The enable is already low during the START cycle, so GAP_LOW lasts one
  // cycle less than GAP to make the detector see exactly GAP low cycles.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_GAP_LOW,
    ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              en_d, lock_q, lock_d, fail_d, err_d;
  logic [23:0]       last_d;
  logic [7:0]        meas_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_s;

  ddr_demet_r u_done_sync (
    .clk   (i_clk),
    .i_rst (~i_rst_n),
    .d     (i_done),
    .q     (done_s)
  );

  // Window limits use 25-bit intermediates so cmp+range cannot wrap and
  // cmp-range clamps at zero instead of underflowing.
  logic [24:0]     cmp_ext, rng_ext, sum_ext, lo_ext, hi_ext, res_ext;
  logic            in_window;
  logic [PASS_W:0] pass_need, pass_next;
  logic            pass_reached, tmo_hit;

  always_comb begin
    cmp_ext      = {1'b0, i_cmp};
    rng_ext      = {15'b0, i_range};
    res_ext      = {1'b0, i_lockresult};
    sum_ext      = cmp_ext + rng_ext;
    lo_ext       = (cmp_ext < rng_ext) ? 25'd0 : cmp_ext - rng_ext;
    hi_ext       = (sum_ext > 25'h0FF_FFFF) ? 25'h0FF_FFFF : sum_ext;
    in_window    = (res_ext >= lo_ext) && (res_ext <= hi_ext);
    pass_need    = (i_pass_cnt == '0) ? (PASS_W+1)'(1) : {1'b0, i_pass_cnt};
    pass_next    = {1'b0, pass_q} + (PASS_W+1)'(1);
    pass_reached = pass_next >= pass_need;
    tmo_hit      = (i_timeout != '0) && (tmo_q == i_timeout - TMO_W'(1));
  end

  // Next-state and next-register logic for the whole sequencer.
  always_comb begin
    state_d = state_q;
    en_d    = o_plllock_en;
    lock_d  = lock_q;
    fail_d  = 1'b0;
    err_d   = o_err_timeout;
    last_d  = o_last_result;
    meas_d  = o_meas_cnt;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (i_enable) begin
          state_d = ST_START;
          err_d   = 1'b0;
          pass_d  = '0;
        end
      end
      ST_START: begin
        en_d    = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done seen in the same cycle as the timeout takes priority.
        if (done_s) begin
          state_d = ST_CHECK;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          en_d    = 1'b0;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        last_d = i_lockresult;
        meas_d = (o_meas_cnt == 8'hFF) ? o_meas_cnt : o_meas_cnt + 8'd1;
        if (in_window) begin
          pass_d = (pass_q == '1) ? pass_q : pass_q + PASS_W'(1);
          if (pass_reached) lock_d = 1'b1;
        end else begin
          pass_d = '0;
          lock_d = 1'b0;
          fail_d = 1'b1;
        end
        en_d    = 1'b0;
        gap_d   = '0;
        state_d = ST_GAP_LOW;
      end
      ST_GAP_LOW: begin
        en_d = 1'b0;
        if (gap_q == GAP_LAST) state_d = ST_START;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      ST_ERR: begin
        en_d = 1'b0;
        if (!i_enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // Dropping enable mid-sequence abandons the current measurement but
    // keeps the last result and the measurement count.
    if (!i_enable && (state_q != ST_IDLE) && (state_q != ST_ERR)) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      lock_d  = 1'b0;
      fail_d  = 1'b0;
      last_d  = o_last_result;
      meas_d  = o_meas_cnt;
      pass_d  = pass_q;
    end
  end

  // State and output registers. o_lock is loaded from the next lock value so
  // it changes in the cycle right after the deciding CHECK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      o_plllock_en  <= 1'b0;
      lock_q        <= 1'b0;
      o_lock        <= 1'b0;
      o_fail        <= 1'b0;
      o_err_timeout <= 1'b0;
      o_last_result <= '0;
      o_meas_cnt    <= '0;
      pass_q        <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      o_plllock_en  <= en_d;
      lock_q        <= lock_d;
      o_lock        <= lock_d | i_force_lock;
      o_fail        <= fail_d;
      o_err_timeout <= err_d;
      o_last_result <= last_d;
      o_meas_cnt    <= meas_d;
      pass_q        <= pass_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_pmon_lockchk.sv
// tb_ddr_pmon_lockchk
//   Scoreboard bench for ddr_pmon_lockchk. Stimulus pushes a detector result
//   and the expected response of a window/consecutive-pass reference model;
//   a detector model answers the enable, and a monitor pops and compares each
//   time the measurement count moves.
module tb_ddr_pmon_lockchk;

  localparam int PASS_W = 4;
  localparam int TMO_W  = 16;
  localparam int GAP    = 4;

  logic              i_clk        = 1'b0;
  logic              i_rst_n      = 1'b0;
  logic              i_enable     = 1'b0;
  logic              i_force_lock = 1'b0;
  logic [23:0]       i_cmp        = '0;
  logic [9:0]        i_range      = '0;
  logic [PASS_W-1:0] i_pass_cnt   = '0;
  logic [TMO_W-1:0]  i_timeout    = '0;
  logic              i_done       = 1'b0;
  logic [23:0]       i_lockresult = '0;
  logic              o_plllock_en, o_busy, o_lock, o_fail, o_err_timeout;
  logic [23:0]       o_last_result;
  logic [7:0]        o_meas_cnt;

  ddr_pmon_lockchk #(.PASS_W(PASS_W), .TMO_W(TMO_W), .GAP(GAP)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_force_lock  (i_force_lock),
    .i_cmp         (i_cmp),
    .i_range       (i_range),
    .i_pass_cnt    (i_pass_cnt),
    .i_timeout     (i_timeout),
    .i_done        (i_done),
    .i_lockresult  (i_lockresult),
    .o_plllock_en  (o_plllock_en),
    .o_busy        (o_busy),
    .o_lock        (o_lock),
    .o_fail        (o_fail),
    .o_err_timeout (o_err_timeout),
    .o_last_result (o_last_result),
    .o_meas_cnt    (o_meas_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] result;
    logic        fail;
    logic        lock;
    logic [7:0]  meas;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] det_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: window, required passes, running pass streak.
  longint m_cmp = 0;
  longint m_rng = 0;
  int     m_need = 1;
  int     m_consec = 0;
  int     m_meas = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Queue one detector result together with the response the model predicts.
  task automatic applyStimulus(input logic [23:0] r);
    longint lo, hi, rv;
    bit     ok;
    exp_t   e;
    rv = longint'(r);
    lo = m_cmp - m_rng;
    if (lo < 0) lo = 0;
    hi = m_cmp + m_rng;
    if (hi > 64'hFF_FFFF) hi = 64'hFF_FFFF;
    ok = (rv >= lo) && (rv <= hi);
    if (ok) m_consec++;
    else    m_consec = 0;
    m_meas   = (m_meas >= 255) ? 255 : m_meas + 1;
    e.result = r;
    e.fail   = !ok;
    e.lock   = (m_consec >= m_need);
    e.meas   = 8'(m_meas);
    exp_q.push_back(e);
    det_q.push_back(r);
  endtask

  task automatic startPhase(input logic [23:0] cmp, input int rng, input int pc);
    @(negedge i_clk);
    i_enable = 1'b0;
    repeat (2) @(negedge i_clk);
    i_cmp      = cmp;
    i_range    = 10'(rng);
    i_pass_cnt = PASS_W'(pc);
    m_cmp      = longint'(cmp);
    m_rng      = longint'(rng);
    m_need     = (pc == 0) ? 1 : pc;
    m_consec   = 0;
    @(negedge i_clk);
    i_enable = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
    det_q.delete();
  endtask

  task automatic waitEnHigh(input string name);
    int n = 0;
    while (!o_plllock_en && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput({"en_rise_", name}, o_plllock_en, 1);
  endtask

  // Detector model: answers each enable after a random delay with the next
  // queued count, and drops done once the enable falls.
  int det_delay = 2;
  always @(negedge i_clk) begin
    if (!o_plllock_en) begin
      i_done = 1'b0;
    end else if (!i_done && det_q.size() > 0) begin
      if (det_delay == 0) begin
        i_lockresult = det_q.pop_front();
        i_done       = 1'b1;
        det_delay    = $urandom_range(0, 5);
      end else begin
        det_delay--;
      end
    end
  end

  // Monitor: a new measurement shows up as a change of o_meas_cnt.
  logic [7:0] prev_meas = '0;
  exp_t       mon_e;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_meas = '0;
    end else begin
      if (o_meas_cnt != prev_meas) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_meas: actual cnt %0d required no measurement", o_meas_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("last_result", o_last_result, mon_e.result);
          checkOutput("fail_pulse", o_fail, mon_e.fail);
          checkOutput("lock", o_lock, mon_e.lock);
          checkOutput("meas_cnt", o_meas_cnt, mon_e.meas);
        end
      end else if (o_fail) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_fail: actual 1 required 0");
      end
      prev_meas = o_meas_cnt;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    logic [23:0] rc;
    int rng, pc, off;
    longint v;

    // Reset state
    repeat (3) @(negedge i_clk);
    checkOutput("rst_en", o_plllock_en, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_lock", o_lock, 0);
    checkOutput("rst_fail", o_fail, 0);
    checkOutput("rst_err", o_err_timeout, 0);
    checkOutput("rst_last", o_last_result, 0);
    checkOutput("rst_meas", o_meas_cnt, 0);
    i_rst_n = 1'b1;

    // Force lock while disabled
    @(negedge i_clk);
    i_force_lock = 1'b1;
    checkOutput("force_before", o_lock, 0);
    @(negedge i_clk);
    checkOutput("force_on", o_lock, 1);
    i_force_lock = 1'b0;
    @(negedge i_clk);
    checkOutput("force_off", o_lock, 0);

    // Basic lock, then window boundaries; also measure the enable gap
    startPhase(24'd1000, 4, 3);
    applyStimulus(24'd1002);
    applyStimulus(24'd1002);
    applyStimulus(24'd1002);
    applyStimulus(24'd996);
    applyStimulus(24'd1004);
    applyStimulus(24'd995);
    applyStimulus(24'd1005);
    waitEnHigh("gap");
    n = 0;
    while (o_plllock_en && n < 200) begin @(negedge i_clk); n++; end
    cnt = 0;
    while (!o_plllock_en && cnt < 50) begin @(negedge i_clk); cnt++; end
    checkOutput("gap_len", cnt, GAP);
    drain("basic");

    // Lock loss and re-lock
    startPhase(24'd1000, 4, 3);
    for (int i = 0; i < 3; i++) applyStimulus(24'd1002);
    applyStimulus(24'd1100);
    for (int i = 0; i < 3; i++) applyStimulus(24'd1000);
    drain("lockloss");

    // Clamped window edges and zero pass target
    startPhase(24'd2, 10, 1);
    applyStimulus(24'd0);
    applyStimulus(24'd12);
    applyStimulus(24'd13);
    drain("lo_clamp");
    startPhase(24'hFFFFFA, 10, 1);
    applyStimulus(24'hFFFFFF);
    applyStimulus(24'hFFFFEF);
    applyStimulus(24'hFFFFF0);
    drain("hi_clamp");
    startPhase(24'd500, 0, 0);
    applyStimulus(24'd500);
    applyStimulus(24'd501);
    applyStimulus(24'd500);
    drain("pc_zero");

    // Enable dropped mid-WAIT while locked
    startPhase(24'd1000, 4, 1);
    applyStimulus(24'd1001);
    drain("abort");
    waitEnHigh("abort");
    repeat (3) @(negedge i_clk);
    checkOutput("abort_locked", o_lock, 1);
    i_enable = 1'b0;
    @(negedge i_clk);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_lock", o_lock, 0);
    checkOutput("abort_en", o_plllock_en, 0);

    // Done-wait timeout
    i_timeout = 16'd50;
    startPhase(24'd1000, 4, 3);
    waitEnHigh("tmo");
    cnt = 0;
    while (o_plllock_en && cnt < 200) begin cnt++; @(negedge i_clk); end
    checkOutput("tmo_wait_len", cnt, 50);
    checkOutput("tmo_err", o_err_timeout, 1);
    checkOutput("tmo_busy", o_busy, 1);
    checkOutput("tmo_en", o_plllock_en, 0);
    i_enable = 1'b0;
    @(negedge i_clk);
    checkOutput("tmo_idle", o_busy, 0);
    checkOutput("tmo_sticky", o_err_timeout, 1);
    i_enable = 1'b1;
    @(negedge i_clk);
    checkOutput("tmo_clear", o_err_timeout, 0);
    @(negedge i_clk);
    checkOutput("tmo_restart", o_plllock_en, 1);
    i_enable  = 1'b0;
    i_timeout = '0;

    // Randomized windows and results
    for (int p = 0; p < 6; p++) begin
      rc = 24'($urandom);
      if (p == 0) rc = 24'd3;
      if (p == 1) rc = 24'hFFFFFE;
      rng = $urandom_range(0, 1023);
      pc  = $urandom_range(0, 4);
      startPhase(rc, rng, pc);
      for (int k = 0; k < 8; k++) begin
        off = int'($urandom_range(0, 2 * rng + 6)) - (rng + 3);
        v = longint'(rc) + longint'(off);
        if (v < 0) v = 0;
        if (v > 64'hFF_FFFF) v = 64'hFF_FFFF;
        applyStimulus(24'(v));
      end
      drain("random");
    end

    // Asynchronous reset during CHECK
    startPhase(24'd1000, 4, 3);
    applyStimulus(24'd1000);
    n = 0;
    while (!i_done && n < 200) begin @(posedge i_clk); n++; end
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("pre_rst_busy", o_busy, 1);
    checkOutput("pre_rst_en", o_plllock_en, 1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", o_busy, 0);
    checkOutput("mid_rst_en", o_plllock_en, 0);
    checkOutput("mid_rst_lock", o_lock, 0);
    checkOutput("mid_rst_meas", o_meas_cnt, 0);
    checkOutput("mid_rst_last", o_last_result, 0);
    exp_q.delete();
    det_q.delete();
    m_meas   = 0;
    i_enable = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_pmon_lockchk.md
Name: ddr_pmon_lockchk

Overview:
- Lock-check sequencer directly downstream of the PMON frequency detector.
- Drives the detector's measurement enable and waits for its done flag.
- Compares each captured PLL-cycle count against a target ± range window and declares PLL lock after N consecutive in-window measurements.
- Flags lock loss, and flags a timeout when the detector never completes; runs in the controller clock domain.

Parameters:
- PASS_W, 4, width of consecutive-pass target and counter
- TMO_W, 16, width of done-wait timeout counter
- GAP, 4, cycles the enable is held low between measurements (≥3 so the detector sees the falling edge)

Ports:
- i_clk  in  1  controller clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  run lock checking; low aborts to IDLE
- i_force_lock  in  1  force o_lock high
- i_cmp  in  24  expected PLL count per measurement window
- i_range  in  10  allowed ± deviation
- i_pass_cnt  in  PASS_W  consecutive passes required (0 treated as 1)
- i_timeout  in  TMO_W  max i_clk cycles to wait for done (0 = no timeout)
- i_done  in  1  detector done, asynchronous; synchronized internally
- i_lockresult  in  24  detector count, stable while done is high
- o_plllock_en  out  1  measurement enable to detector
- o_busy  out  1  state != IDLE
- o_lock  out  1  lock status
- o_fail  out  1  one-cycle pulse on each out-of-window result
- o_err_timeout  out  1  sticky done-wait timeout
- o_last_result  out  24  last captured i_lockresult
- o_meas_cnt  out  8  measurements completed, saturating at 8'hFF

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Synchronization:
  - i_done passes through a 2-flop demet (ddr_demet_r, i_rst driven by ~i_rst_n); done_s is the synchronizer output.
  - i_lockresult is sampled only in CHECK, when it is quasi-static; it gets no synchronizer.
- Window:
  - lo = (i_cmp < i_range) ? 0 : i_cmp − i_range.
  - hi = (i_cmp + i_range > 24'hFFFFFF) ? 24'hFFFFFF : i_cmp + i_range.
  - Use 25-bit intermediates. Pass = lo ≤ result ≤ hi, inclusive at both ends.
- States: IDLE, START, WAIT, CHECK, GAP_LOW, ERR.
- IDLE:
  - o_plllock_en = 0.
  - When i_enable = 1: go to START, clear o_err_timeout and the pass counter.
- START:
  - Set o_plllock_en = 1, clear the timeout counter, go to WAIT.
  - o_plllock_en is a register; it is high from the first WAIT cycle.
- WAIT:
  - Stay in WAIT while done_s = 0; the timeout counter increments each cycle.
  - If i_timeout ≠ 0 and count == i_timeout − 1: set o_err_timeout, clear lock_q, go to ERR.
  - When done_s = 1: go to CHECK.
- CHECK (one cycle):
  - o_last_result ← i_lockresult; o_meas_cnt increments, saturating.
  - On pass: pass_cnt increments, saturating. When pass_cnt + 1 ≥ max(i_pass_cnt, 1), set lock_q.
  - On fail: clear pass_cnt and lock_q, and pulse o_fail on the next cycle.
  - Then go to GAP_LOW.
- GAP_LOW:
  - o_plllock_en = 0 for exactly GAP cycles, then go to START.
  - Monitoring continues indefinitely while enabled.
- ERR:
  - o_plllock_en = 0; hold until i_enable = 0, then go to IDLE.
  - o_err_timeout remains set until the next IDLE→START transition.
- Output register:
  - o_lock = registered (lock_q | i_force_lock); force takes effect 1 cycle after assertion.
  - With force low, o_lock rises in the cycle after the passing CHECK.
- Abort: i_enable = 0 in any state other than ERR → IDLE next cycle; o_plllock_en = 0 and lock_q = 0 at that clock edge. o_last_result and o_meas_cnt are kept.
- Simultaneous events in WAIT: if done_s = 1 and timeout are both true in the same cycle, done wins and the FSM goes to CHECK.
- Asynchronous reset mid-operation: everything returns to reset values immediately.

Test Plan:
- Basic lock:
  - Stimulus: cmp = 1000, range = 4, pass_cnt = 3, detector model returns 1002 each time.
  - Response: three CHECK cycles, o_lock rises after the 3rd, o_meas_cnt = 3, o_fail never pulses.
- Boundaries:
  - Stimulus: results 996, 1004, 995, 1005.
  - Response: first two pass; 995 and 1005 each produce an o_fail pulse and reset the pass count.
  - Stimulus: cmp = 2, range = 10 → lo = 0; result 0.
  - Response: pass.
  - Stimulus: cmp = 24'hFFFFFA, range = 10 → hi = 24'hFFFFFF; result 24'hFFFFFF.
  - Response: pass.
- Lock loss:
  - Stimulus: after lock, one result of 1100.
  - Response: o_fail pulses once, o_lock falls the next cycle, and 3 new passes are needed to re-lock.
- Timeout:
  - Stimulus: i_timeout = 50, done held low.
  - Response: o_err_timeout set after 50 WAIT cycles, state ERR, o_plllock_en = 0.
  - Stimulus: drop then raise i_enable.
  - Response: error clears and a new measurement starts.
- Enable/gap timing:
  - Response: o_plllock_en is low for exactly GAP cycles between measurements.
  - Stimulus: i_enable dropped mid-WAIT.
  - Response: IDLE next cycle, o_lock = 0.
- Force:
  - Stimulus: i_force_lock = 1 with i_enable = 0.
  - Response: o_lock = 1 one cycle later; o_lock drops one cycle after force is released.
  - Stimulus: reset asserted during CHECK.
  - Response: all outputs 0 immediately.
